iterative_shift_controller: RTL

- Multi-cycle variable-amount shifter controller that sequences a fixed-step shift datapath of at most STEP bits per cycle.
- It accepts one shift request at a time over a valid/ready handshake and iterates the step shifter until the requested amount is consumed.
- It presents the result on a valid/ready output port.
- It sits between a request source (e.g. an ALU issue stage) and its consumer, and replaces a wide single-cycle barrel shifter.

---
 rtl/iterative_shift_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/iterative_shift_controller.sv
// Multi-cycle variable-amount shifter: takes one request at a time and walks
// a shifter of at most STEP bits per cycle until the clamped amount is used up.
module iterative_shift_controller #(
    parameter int N    = 8,
    parameter int STEP = 3,
    localparam int W   = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [W-1:0] in_amt,
    input  logic         in_dir,
    input  logic         in_arith,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy,
    output logic [15:0]  ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [W-1:0] STEP_W = W'(STEP);
    localparam logic [W-1:0] N_W    = W'(N);

    state_t        state_q;
    logic [N-1:0]  data_q;
    logic [W-1:0]  rem_q;
    logic          dir_q;
    logic          arith_q;
    logic [15:0]   ops_q;

    logic [W-1:0]  amt_clamp;
    logic [W-1:0]  step_k;
    logic [N-1:0]  data_d;
    logic [W-1:0]  rem_d;
    logic signed [N-1:0] data_s;

    assign amt_clamp = (in_amt > N_W) ? N_W : in_amt;
    assign step_k    = (rem_q < STEP_W) ? rem_q : STEP_W;
    assign data_s    = data_q;
    assign rem_d     = rem_q - step_k;

    // Arithmetic shift keeps the working MSB, which is always the original
    // sign bit, so repeated partial steps still sign-fill correctly.
    always_comb begin
        data_d = data_q;
        if (!dir_q) begin
            data_d = data_q << step_k;
        end else if (arith_q) begin
            data_d = data_s >>> step_k;
        end else begin
            data_d = data_q >> step_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            ops_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        dir_q   <= in_dir;
                        arith_q <= in_arith;
                        rem_q   <= amt_clamp;
                        state_q <= (amt_clamp == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        ops_q   <= ops_q + 16'd1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst_n so it drops the instant reset asserts.
    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = data_q;
    assign ops_done  = ops_q;

endmodule
